// File: rtl/sap1_pkg.sv
// Shared SAP-1 types and widths for the manual programming front end.
package sap1_pkg;

  localparam int unsigned SAP1_ADDR_W = 4;
  localparam int unsigned SAP1_DATA_W = 8;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  // Address pointer step; wraps naturally at the 4-bit boundary.
  function automatic logic [SAP1_ADDR_W-1:0] addr_inc(input logic [SAP1_ADDR_W-1:0] a);
    return a + {{(SAP1_ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sap1_prog_loader_if.sv
// Front-panel switches in, address-mux / RAM-write signals out.
interface sap1_prog_loader_if;
  import sap1_pkg::*;

  logic                   run_sw;
  logic                   write_btn;
  logic                   auto_inc;
  logic [SAP1_ADDR_W-1:0] addr_sw;
  logic [SAP1_DATA_W-1:0] data_sw;
  logic                   mux_select;
  logic [SAP1_ADDR_W-1:0] man_addr;
  logic [SAP1_DATA_W-1:0] ram_wdata;
  logic                   ram_we;
  logic                   busy;
  logic                   run_ok;

  modport master (
    output run_sw, write_btn, auto_inc, addr_sw, data_sw,
    input  mux_select, man_addr, ram_wdata, ram_we, busy, run_ok
  );

  modport slave (
    input  run_sw, write_btn, auto_inc, addr_sw, data_sw,
    output mux_select, man_addr, ram_wdata, ram_we, busy, run_ok
  );

endinterface

// File: rtl/sap1_debounce.sv
// Two-flop synchroniser, stability counter and one-cycle pulse on an accepted 0->1 change.
module sap1_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic            sync1_q, sync2_q, level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise    <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      rise    <= 1'b0;
      // Any glitch back to the accepted level restarts the stability window.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        rise    <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/sap1_prog_loader.sv
// Manual RAM programming front end: debounced WRITE, setup/strobe/hold write cycle,
// and hand-over of the 74157 address mux to the bus side in run mode.
module sap1_prog_loader
  import sap1_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned WE_CYC     = 2
) (
  input logic               clk,
  input logic               clr_n,
  sap1_prog_loader_if.slave bus
);

  localparam int unsigned TmrMax = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  state_e                 state_q;
  logic [TmrW-1:0]        tmr_q;
  logic [SAP1_ADDR_W-1:0] ptr_q, man_addr_q;
  logic [SAP1_DATA_W-1:0] wdata_q;
  logic                   inc_q, we_q, busy_q, sel_q;
  logic                   run_s1_q, run_s;
  logic                   wr_req;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      run_s1_q <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      run_s1_q <= bus.run_sw;
      run_s    <= run_s1_q;
    end
  end

  sap1_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .clr_n(clr_n),
    .raw  (bus.write_btn),
    .rise (wr_req)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      ptr_q      <= '0;
      man_addr_q <= '0;
      wdata_q    <= '0;
      inc_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sel_q      <= run_s;
          man_addr_q <= bus.auto_inc ? ptr_q : bus.addr_sw;
          if (wr_req && !run_s) begin
            state_q <= StSetup;
            busy_q  <= 1'b1;
            wdata_q <= bus.data_sw;
            // auto_inc is captured here so a mid-write change cannot move the pointer.
            inc_q   <= bus.auto_inc;
            tmr_q   <= '0;
          end
        end
        StSetup: begin
          if (run_s) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            sel_q   <= 1'b1;
          end else if (tmr_q == TmrW'(SETUP_CYC - 1)) begin
            state_q <= StStrobe;
            we_q    <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StStrobe: begin
          if (tmr_q == TmrW'(WE_CYC - 1)) begin
            state_q <= StHold;
            we_q    <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StHold: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          // Select is loaded on the edge that enters IDLE, so it only ever rises in IDLE.
          sel_q   <= run_s;
          if (inc_q) ptr_q <= addr_inc(ptr_q);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mux_select = sel_q;
  assign bus.run_ok     = sel_q;
  assign bus.man_addr   = man_addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_we     = we_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed bench: loader drives a 74157 model; writes land in a small RAM model.
module tb_sap1_prog_loader;
  import sap1_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned SETUP = 2;
  localparam int unsigned WE    = 2;
  localparam logic [3:0]  BUS_D = 4'h9;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sap1_prog_loader_if bus ();

  sap1_prog_loader #(
    .DEB_CYCLES(DEB),
    .SETUP_CYC (SETUP),
    .WE_CYC    (WE)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // 74157 model: select=0 passes a (manual), select=1 passes d (bus side).
  logic [3:0] mux_y;
  assign mux_y = bus.mux_select ? BUS_D : bus.man_addr;

  logic [7:0] ram [16];
  always @(posedge clk) if (bus.ram_we) ram[mux_y] <= bus.ram_wdata;

  typedef struct {
    int         pulses, we_cycles, first_we, we_fall, busy_rise, busy_fall, accept, sel_rise;
    logic [3:0] addr;
    logic [7:0] data;
    logic       sel;
  } obs_t;

  typedef struct {
    logic       run, auto_i;
    logic [3:0] addr;
    logic [7:0] data;
    int         exp_pulses;
    logic [3:0] exp_addr;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Press (optionally bouncing), hold 19 cycles, release; watch a fixed 30-cycle window.
  task automatic press(input logic bounce, input int run_at, output obs_t o);
    logic pw, pb, ps, pl;
    o = '{pulses: 0, we_cycles: 0, first_we: -1, we_fall: -1, busy_rise: -1, busy_fall: -1,
          accept: -1, sel_rise: -1, addr: '0, data: '0, sel: 1'b0};
    if (bounce) begin
      bus.write_btn = 1'b1; tick();
      bus.write_btn = 1'b0; tick();
    end
    bus.write_btn = 1'b1;
    pw = bus.ram_we; pb = bus.busy; ps = bus.mux_select; pl = dut.u_deb.level_q;
    for (int t = 1; t <= 30; t++) begin
      if (t == 20) bus.write_btn = 1'b0;
      tick();
      if (bus.ram_we && !pw) begin
        o.pulses++; o.first_we = t; o.addr = mux_y; o.data = bus.ram_wdata;
        o.sel = bus.mux_select;
      end
      if (bus.ram_we) o.we_cycles++;
      if (!bus.ram_we && pw) o.we_fall = t;
      if (bus.busy && !pb && o.busy_rise < 0) o.busy_rise = t;
      if (!bus.busy && pb && o.busy_fall < 0) o.busy_fall = t;
      if (dut.u_deb.level_q && !pl && o.accept < 0) o.accept = t;
      if (bus.mux_select && !ps && o.sel_rise < 0) o.sel_rise = t;
      pw = bus.ram_we; pb = bus.busy; ps = bus.mux_select; pl = dut.u_deb.level_q;
      if (t == run_at) bus.run_sw = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs [4];
    obs_t o;

    vecs[0] = '{run: 0, auto_i: 0, addr: 4'hA, data: 8'h5C, exp_pulses: 1, exp_addr: 4'hA};
    vecs[1] = '{run: 0, auto_i: 0, addr: 4'h3, data: 8'hC3, exp_pulses: 1, exp_addr: 4'h3};
    vecs[2] = '{run: 1, auto_i: 0, addr: 4'h7, data: 8'h11, exp_pulses: 0, exp_addr: BUS_D};
    vecs[3] = '{run: 0, auto_i: 0, addr: 4'hF, data: 8'hFF, exp_pulses: 1, exp_addr: 4'hF};

    bus.run_sw = 0; bus.write_btn = 0; bus.auto_inc = 0; bus.addr_sw = 0; bus.data_sw = 0;

    // 1: reset
    #1 clr_n = 1'b0;
    repeat (3) tick();
    chk("rst_sel", 32'(bus.mux_select), 0);
    chk("rst_addr", 32'(bus.man_addr), 0);
    chk("rst_wdata", 32'(bus.ram_wdata), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_run_ok", 32'(bus.run_ok), 0);
    chk("rst_mux_y", 32'(mux_y), 0);
    clr_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_we", 32'(bus.ram_we), 0);

    // 2: table of manual writes, including a press ignored in run mode
    foreach (vecs[i]) begin
      bus.run_sw = vecs[i].run; bus.auto_inc = vecs[i].auto_i;
      bus.addr_sw = vecs[i].addr; bus.data_sw = vecs[i].data;
      repeat (4) tick();
      press(1'b0, 0, o);
      chk($sformatf("v%0d_pulses", i), 32'(o.pulses), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses == 1) begin
        chk($sformatf("v%0d_we_len", i), 32'(o.we_cycles), WE);
        chk($sformatf("v%0d_addr", i), 32'(o.addr), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_data", i), 32'(o.data), 32'(vecs[i].data));
        chk($sformatf("v%0d_sel_during_we", i), 32'(o.sel), 0);
        chk($sformatf("v%0d_first_we", i), 32'(o.first_we), DEB + 3 + SETUP);
        chk($sformatf("v%0d_busy_fall", i), 32'(o.busy_fall), 32'(o.we_fall + 1));
        chk($sformatf("v%0d_ram", i), 32'(ram[vecs[i].exp_addr]), 32'(vecs[i].data));
      end else begin
        chk($sformatf("v%0d_busy_rise", i), 32'(o.busy_rise), 32'(-1));
        chk($sformatf("v%0d_run_ok", i), 32'(bus.run_ok), 1);
        chk($sformatf("v%0d_mux_y", i), 32'(mux_y), 32'(vecs[i].exp_addr));
      end
    end

    // 3: bouncing button
    bus.run_sw = 0; bus.addr_sw = 4'h5; bus.data_sw = 8'h66;
    repeat (4) tick();
    press(1'b1, 0, o);
    chk("bounce_pulses", 32'(o.pulses), 1);
    chk("bounce_accept", 32'(o.accept), DEB + 2);
    chk("bounce_busy_rise", 32'(o.busy_rise), DEB + 3);
    chk("bounce_ram", 32'(ram[5]), 32'h66);

    // 4: auto-increment through the wrap
    bus.auto_inc = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.data_sw = 8'(i + 8'h20);
      repeat (2) tick();
      press(1'b0, 0, o);
      chk($sformatf("auto%0d_addr", i), 32'(o.addr), 32'(i % 16));
      chk($sformatf("auto%0d_pulses", i), 32'(o.pulses), 1);
    end
    chk("auto_ptr_end", 32'(dut.ptr_q), 1);
    chk("auto_man_addr_end", 32'(bus.man_addr), 1);

    // 5a: run_s rises during SETUP -> abort
    press(1'b0, DEB + 2, o);
    chk("abort_pulses", 32'(o.pulses), 0);
    chk("abort_busy_rise", 32'(o.busy_rise), DEB + 3);
    chk("abort_ptr", 32'(dut.ptr_q), 1);
    chk("abort_sel", 32'(bus.mux_select), 1);
    chk("abort_mux_y", 32'(mux_y), 32'(BUS_D));
    bus.run_sw = 0;
    repeat (4) tick();
    chk("back_to_prog_sel", 32'(bus.mux_select), 0);

    // 5b: run_s rises during STROBE -> write completes, select follows
    press(1'b0, DEB + 1 + SETUP, o);
    chk("defer_pulses", 32'(o.pulses), 1);
    chk("defer_we_len", 32'(o.we_cycles), WE);
    chk("defer_addr", 32'(o.addr), 1);
    chk("defer_ptr", 32'(dut.ptr_q), 2);
    chk("defer_sel_latency_ok",
        32'(o.sel_rise > 0 && o.sel_rise - (DEB + 3 + SETUP) <= int'(WE) + 1), 1);
    chk("defer_run_ok", 32'(bus.run_ok), 1);
    bus.run_sw = 0;
    repeat (4) tick();

    // 6: asynchronous reset during STROBE
    bus.write_btn = 1'b1;
    repeat (DEB + 3 + SETUP) tick();
    chk("strobe_we_before_rst", 32'(bus.ram_we), 1);
    #3 clr_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.ram_we), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_state", 32'(dut.state_q), 32'(StIdle));
    chk("arst_ptr", 32'(dut.ptr_q), 0);
    chk("arst_man_addr", 32'(bus.man_addr), 0);
    chk("arst_wdata", 32'(bus.ram_wdata), 0);
    bus.write_btn = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
    repeat (8) tick();
    chk("arst_after_we", 32'(bus.ram_we), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
